// File: rtl/fifo_pkg.sv
// Shared sizing constants for the four-entry synchronous FIFO.
// The pointer carries one extra wrap bit above the address.
package fifo_pkg;

  localparam int FIFO_DEPTH  = 4;
  localparam int FIFO_ADDR_W = 2;
  localparam int FIFO_PTR_W  = 3;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer for one side of the FIFO: clears on reset, advances modulo 8 on inc.
module fifo_ptr
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [FIFO_PTR_W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sync4.sv
// Four-entry single-clock byte FIFO with registered read data, occupancy count
// and one-cycle overflow/underflow error pulses.
module fifo_sync4
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     din,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     dout,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_PTR_W-1:0] count,
  output logic                  wr_err,
  output logic                  rd_err
);

  logic [DATA_W-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  addr_eq;

  fifo_ptr u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_ok),
    .ptr (rd_ptr)
  );

  // Flags decode from registered pointers only, so they never see same-cycle requests.
  assign addr_eq = (wr_ptr[FIFO_ADDR_W-1:0] == rd_ptr[FIFO_ADDR_W-1:0]);
  assign empty   = addr_eq && (wr_ptr[FIFO_ADDR_W] == rd_ptr[FIFO_ADDR_W]);
  assign full    = addr_eq && (wr_ptr[FIFO_ADDR_W] != rd_ptr[FIFO_ADDR_W]);

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[FIFO_ADDR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      wr_err   <= wr_en && full;
      rd_err   <= rd_en && empty;
      if (rd_ok) begin
        dout <= mem[rd_ptr[FIFO_ADDR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync4.sv
// Directed bench for fifo_sync4: a reference occupancy model plus a data queue
// predicts every flag, pulse and read word.
module tb_fifo_sync4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       wr_err;
  logic       rd_err;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_cnt = 0;
  logic [7:0] m_dout = 8'h00;
  logic [7:0] sb [$];

  fifo_sync4 #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .din      (din),
    .rd_en    (rd_en),
    .dout     (dout),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .wr_err   (wr_err),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk8({tag, "_count"}, 8'(count), 8'(m_cnt));
    chk1({tag, "_full"}, full, m_cnt == 4);
    chk1({tag, "_empty"}, empty, m_cnt == 0);
  endtask

  // One clock cycle of stimulus; outputs are checked 1 time unit after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input string tag);
    bit wa, ra;
    logic [7:0] exp_d;
    wa = w && (m_cnt < 4);
    ra = r && (m_cnt > 0);
    wr_en = w;
    din   = d;
    rd_en = r;
    if (wa) sb.push_back(d);
    @(posedge clk);
    #1;
    if (wa && !ra) m_cnt++;
    else if (ra && !wa) m_cnt--;
    chk1({tag, "_rd_valid"}, rd_valid, ra);
    if (rd_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL %s_sb_underrun: observed rd_valid=1 expected no data", tag);
      end else begin
        exp_d  = sb.pop_front();
        m_dout = exp_d;
      end
    end
    chk8({tag, "_dout"}, dout, m_dout);
    chk1({tag, "_wr_err"}, wr_err, w && !wa);
    chk1({tag, "_rd_err"}, rd_err, r && !ra);
    chk_flags(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_flags("reset");
    chk8("reset_dout", dout, 8'h00);
    chk1("reset_rd_valid", rd_valid, 1'b0);
    chk1("reset_wr_err", wr_err, 1'b0);
    chk1("reset_rd_err", rd_err, 1'b0);
    step(1'b0, 8'h00, 1'b0, "idle");

    // Fill, overflow, drain, underflow.
    step(1'b1, 8'h11, 1'b0, "fill0");
    step(1'b1, 8'h22, 1'b0, "fill1");
    step(1'b1, 8'h33, 1'b0, "fill2");
    step(1'b1, 8'h44, 1'b0, "fill3");
    step(1'b1, 8'h55, 1'b0, "overflow");
    step(1'b0, 8'h00, 1'b0, "after_ovf");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, "drain");
    step(1'b0, 8'h00, 1'b1, "underflow");
    step(1'b0, 8'h00, 1'b0, "after_unf");

    // Both requests at the full and empty boundaries.
    step(1'b1, 8'h66, 1'b0, "fill_b0");
    step(1'b1, 8'h77, 1'b0, "fill_b1");
    step(1'b1, 8'h88, 1'b0, "fill_b2");
    step(1'b1, 8'h99, 1'b0, "fill_b3");
    step(1'b1, 8'hAA, 1'b1, "both_full");
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "drain_b");
    step(1'b1, 8'hA5, 1'b1, "both_empty");
    step(1'b0, 8'h00, 1'b1, "read_a5");

    // Continuous streaming across several pointer wraps.
    step(1'b1, 8'h00, 1'b0, "wrap_pre0");
    step(1'b1, 8'h01, 1'b0, "wrap_pre1");
    for (int i = 2; i < 20; i++) step(1'b1, 8'(i), 1'b1, "wrap");
    step(1'b0, 8'h00, 1'b1, "wrap_tail0");
    step(1'b0, 8'h00, 1'b1, "wrap_tail1");

    // Steady state at two entries.
    step(1'b1, 8'hB0, 1'b0, "steady_pre0");
    step(1'b1, 8'hB1, 1'b0, "steady_pre1");
    for (int i = 0; i < 10; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1, "steady");
    step(1'b0, 8'h00, 1'b1, "steady_tail0");
    step(1'b0, 8'h00, 1'b1, "steady_tail1");

    // Asynchronous reset with two entries stored.
    step(1'b1, 8'hD0, 1'b0, "prerst0");
    step(1'b1, 8'hD1, 1'b0, "prerst1");
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
    chk_flags("async_rst");
    chk8("async_rst_dout", dout, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b1, "post_rst_rd");
    step(1'b1, 8'hE7, 1'b0, "post_rst_wr");
    step(1'b0, 8'h00, 1'b1, "post_rst_rd2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync4.md
# fifo_sync4

Four-entry synchronous FIFO that pairs a write side and a read side around a shared register array. Pointer generation, storage and flag logic live here; full/empty come from address equality plus a wrap bit. It buffers bytes between a producer and a consumer running on the same clock.

## Interface

Parameters:
- DATA_W, 8, data word width
- DEPTH, 4, entry count; fixed, not overridable; address width 2, pointer width 3 (address + wrap bit)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- din  in  DATA_W  write data, sampled with wr_en
- rd_en  in  1  read request
- dout  out  DATA_W  read data, registered
- rd_valid  out  1  dout holds a newly read word this cycle
- full  out  1  4 entries stored
- empty  out  1  0 entries stored
- count  out  3  occupancy, 0..4
- wr_err  out  1  one-cycle pulse: write requested while full
- rd_err  out  1  one-cycle pulse: read requested while empty

## Operation

- wr_ptr and rd_ptr are each 3 bits: bit 2 = wrap, bits 1:0 = address.
- empty = (wr_ptr[1:0] == rd_ptr[1:0]) and (wr_ptr[2] == rd_ptr[2]).
- full = (wr_ptr[1:0] == rd_ptr[1:0]) and (wr_ptr[2] != rd_ptr[2]).
- Write accepted = wr_en and not full. The edge stores din at mem[wr_ptr[1:0]] and increments wr_ptr modulo 8.
- Read accepted = rd_en and not empty. The edge loads dout from mem[rd_ptr[1:0]], sets rd_valid and increments rd_ptr modulo 8.
- Rejected requests change no pointer or storage. They pulse wr_err/rd_err for one cycle.
- count = wr_ptr − rd_ptr, modulo 8. It is registered: updated +1 on write only, −1 on read only, unchanged on both or neither.
- Flags are evaluated on pre-edge state:
  - Both requests while full: the read is accepted and the write is rejected (wr_err=1).
  - Both requests while empty: the write is accepted and the read is rejected (rd_err=1).
  - Both requests with 1..3 entries: both are accepted and count is unchanged.
- dout holds its last value when no read is accepted. rd_valid is 0 in that cycle.
- Wrap-around: the address rolls 3→0 and toggles the wrap bit. Flags stay correct across any number of wraps.

## Timing

- Reset (async assert, sync-free deassert):
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0
  - dout=0, rd_valid=0, wr_err=0, rd_err=0
  - mem contents are not reset (don't-care).
- Reset mid-operation discards all stored entries immediately. The first edge after deassert behaves as an empty FIFO.
- Write-to-read latency:
  - A word written at edge N makes empty=0 after edge N.
  - A read issued in cycle N+1 yields dout/rd_valid after edge N+1.
  - There is no fall-through.
- Read latency is 1 cycle: rd_en at edge N means dout valid from edge N until the next accepted read.
- full, empty and count are registered, or decoded combinationally from registered pointers only. They never depend on same-cycle wr_en/rd_en.
- wr_err/rd_err are registered and high for exactly one cycle per rejected request.

## Structure

- Shared package fifo_pkg: constants FIFO_DEPTH=4, FIFO_ADDR_W=2, FIFO_PTR_W=3.
- Sub-module fifo_ptr, instantiated twice (write and read side):
  - Inputs: clk, rst, inc.
  - Output: 3-bit pointer.
  - Behaviour: async active-high reset to 0, modulo-8 increment.
- Storage, flag decode and count logic are in the top module.

## Test plan

- Reset then idle:
  - Expect empty=1, full=0, count=0, dout=0, rd_valid=0.
  - Assert rst mid-stream with 2 entries stored; expect count=0 and empty=1 immediately, without waiting for a clock.
- Fill and drain:
  - Write 0x11, 0x22, 0x33, 0x44; expect full=1 and count=4.
  - Then read 4 times; expect dout 0x11, 0x22, 0x33, 0x44 with rd_valid each cycle, then empty=1.
- Overflow/underflow:
  - Write 0x55 while full; expect wr_err pulse, count stays 4, and the later read sequence is unchanged.
  - Read while empty; expect rd_err pulse and dout holding its last value.
- Simultaneous at boundaries:
  - Full with both requests: read returns the oldest word, write rejected, count=3.
  - Empty with both requests and din=0xA5: count=1, rd_err=1, and the next read returns 0xA5.
- Wrap-around: stream 20 words (0x00..0x13) with continuous write and read at 1..3 occupancy; expect in-order data, no err pulses, and correct flags across 5 pointer wraps.
- Steady state: with 2 entries stored, hold wr_en and rd_en high for 10 cycles; expect count=2 throughout and FIFO order preserved.
